// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with a level interrupt request.
// Registers: CTRL (EN, MODE, IM), PRESET (reload value), COUNT (read-only).
// Optional feature macro: TIMER_AUTORELOAD_EN. When it is defined, CTRL[2:1]
// (MODE) is stored and MODE=1 selects auto-reload. When it is undefined,
// MODE is not stored, it reads 0, and every expiry is one-shot.
// Reads are combinational so the bridge can answer in the same cycle.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic        im_q, im_d;
  logic        flag_q, flag_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  mode_rd;
  logic        reload;
  logic        ctrl_wr;
  logic        preset_wr;

  assign ctrl_wr   = we && (addr == AddrCtrl);
  assign preset_wr = we && (addr == AddrPreset);

`ifdef TIMER_AUTORELOAD_EN
  logic [1:0] mode_q, mode_d;

  // Only MODE=1 reloads; 2 and 3 fall back to one-shot behaviour.
  assign reload  = (mode_q == 2'd1);
  assign mode_rd = mode_q;

  // MODE register; the CPU write is its only source.
  always_comb begin
    mode_d = mode_q;
    if (ctrl_wr) mode_d = wdata[2:1];
  end

  // MODE storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mode_q <= 2'd0;
    else        mode_q <= mode_d;
  end
`else
  assign reload  = 1'b0;
  assign mode_rd = 2'd0;
`endif

  // Next-state logic: FSM update first, CPU writes applied last so they win.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    im_d     = im_q;
    flag_d   = flag_q;
    preset_d = preset_q;
    count_d  = count_q;

    unique case (state_q)
      StIdle: begin
        if (en_q) state_d = StLoad;
      end
      StLoad: begin
        // Reload happens even if EN dropped in the meantime.
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en_q) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Covers COUNT==0 too, so PRESET=0 expires like PRESET=1.
          count_d = 32'd0;
          flag_d  = 1'b1;
          state_d = StInt;
        end
      end
      StInt: begin
        state_d = StIdle;
        if (reload) flag_d = 1'b0;
        else        en_d   = 1'b0;
      end
    endcase

    if (ctrl_wr) begin
      en_d   = wdata[0];
      im_d   = wdata[3];
      flag_d = 1'b0;
    end
    if (preset_wr) preset_d = wdata;
  end

  // State and register storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      im_q     <= 1'b0;
      flag_q   <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      im_q     <= im_d;
      flag_q   <= flag_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  // Zero-latency register read mux; the reserved slot reads 0.
  always_comb begin
    rdata = 32'd0;
    unique case (addr)
      AddrCtrl:   rdata = {28'd0, im_q, mode_rd, en_q};
      AddrPreset: rdata = preset_q;
      AddrCount:  rdata = count_q;
      default:    rdata = 32'd0;
    endcase
  end

  assign irq = flag_q & im_q;

endmodule
